tdd_frame_gate: RTL and testbench

Downstream consumer of the TDD sync pulse generator. On each sync rising edge it starts a programmable frame timer and opens a transmit window. The window gates an AXI-Stream DMA path, so samples flow only inside the configured slot. The block sits between the sync pulse generator and the DMA/PSK sample stream.

---
 rtl/tdd_gate_pkg.sv | 14 +
 rtl/tdd_axis_gate.sv | 24 ++
 rtl/tdd_frame_gate.sv | 214 +++++++++++++++++++++
 tb/tb_tdd_frame_gate.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdd_gate_pkg.sv
// Shared types and width helpers for the TDD frame gate.
package tdd_gate_pkg;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Extra bit added to counter-width compares so delay+on_len cannot overflow.
    localparam int unsigned CNT_EXT_W = 1;

endpackage

// File: rtl/tdd_axis_gate.sv
// Combinational AXI-Stream window gate with overrun detection.
module tdd_axis_gate #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              window_en,
    input  logic              window_en_nxt,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              overrun_set_c
);

    // Handshakes only open inside the window; data is held upstream otherwise.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = s_axis_tvalid & window_en;
    assign s_axis_tready = m_axis_tready & window_en;

    // Window is about to close while the source still has data pending.
    assign overrun_set_c = window_en & ~window_en_nxt & s_axis_tvalid;

endmodule

// File: rtl/tdd_frame_gate.sv
// Sync-triggered frame timer that opens a transmit window gating an AXI-Stream path.
module tdd_frame_gate
    import tdd_gate_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter bit          RESYNC_EN = 1'b1,
    parameter int unsigned DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              sync_in,
    input  logic              arm,
    input  logic              stop,
    input  logic [CNT_W-1:0]  cfg_frame_len,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_on_len,
    input  logic [CNT_W-1:0]  cfg_num_frames,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              window_en,
    output logic              frame_start,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic              win_overrun
);

    localparam int unsigned EXT_W = CNT_W + CNT_EXT_W;

    state_e             state_q;
    state_e             state_nxt;

    logic               sync_in_d;
    logic               sync_edge;
    logic               resync;

    logic [CNT_W-1:0]   sh_frame_len;
    logic [CNT_W-1:0]   sh_delay;
    logic [CNT_W-1:0]   sh_on_len;
    logic [CNT_W-1:0]   sh_num_frames;

    logic [CNT_W-1:0]   pos_q;
    logic [CNT_W-1:0]   pos_nxt;
    logic [CNT_W-1:0]   frame_cnt_nxt;

    logic               cfg_ok;
    logic               arm_accept;
    logic               wrap;
    logic               last_frame;

    logic               window_nxt;
    logic               frame_start_nxt;
    logic               done_nxt;
    logic               cfg_err_nxt;
    logic               busy_nxt;
    logic               overrun_set_c;

    // Rising edge of the upstream sync pulse.
    assign sync_edge = sync_in & ~sync_in_d;
    assign resync    = RESYNC_EN & sync_edge;

    assign cfg_ok     = (cfg_frame_len >= CNT_W'(2));
    assign arm_accept = (state_q == IDLE) && (state_nxt == ARMED);
    assign wrap       = (pos_q == sh_frame_len - CNT_W'(1));

    // Run ends at the wrap that completes the programmed count; >= keeps a
    // resync-advanced count from skipping past the terminal value.
    assign last_frame = (sh_num_frames != '0) &&
                        ((EXT_W'(frame_cnt) + EXT_W'(1)) >= EXT_W'(sh_num_frames));

    // State register.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic; stop outranks arm and sync in every state.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: begin
                if (!stop && arm && cfg_ok) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (sync_edge) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (wrap && last_frame) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output/counter logic: next values of every registered output.
    always_comb begin
        pos_nxt         = '0;
        frame_cnt_nxt   = frame_cnt;
        window_nxt      = 1'b0;
        frame_start_nxt = 1'b0;
        done_nxt        = 1'b0;
        cfg_err_nxt     = 1'b0;
        busy_nxt        = (state_nxt != IDLE);

        case (state_q)
            IDLE: begin
                if (arm_accept) begin
                    frame_cnt_nxt = '0;
                end
                cfg_err_nxt = arm && !stop && !cfg_ok;
            end
            ARMED: begin
                pos_nxt = '0;
            end
            RUN: begin
                if (!stop) begin
                    if (wrap || resync) begin
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    end else begin
                        pos_nxt = pos_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                pos_nxt = '0;
            end
        endcase

        // Window, frame-start and done all track the position of the next cycle.
        if (state_nxt == RUN) begin
            window_nxt      = (EXT_W'(pos_nxt) >= EXT_W'(sh_delay)) &&
                              (EXT_W'(pos_nxt) <  EXT_W'(sh_delay) + EXT_W'(sh_on_len));
            frame_start_nxt = (pos_nxt == '0);
            done_nxt        = (pos_nxt == sh_frame_len - CNT_W'(1)) &&
                              (sh_num_frames != '0) &&
                              ((EXT_W'(frame_cnt_nxt) + EXT_W'(1)) >= EXT_W'(sh_num_frames));
        end
    end

    // Shadow configuration, frozen between accepted arms.
    always_ff @(posedge clk) begin
        if (rstn) begin
            sh_frame_len  <= '0;
            sh_delay      <= '0;
            sh_on_len     <= '0;
            sh_num_frames <= '0;
        end else if (arm_accept) begin
            sh_frame_len  <= cfg_frame_len;
            sh_delay      <= cfg_delay;
            sh_on_len     <= cfg_on_len;
            sh_num_frames <= cfg_num_frames;
        end
    end

    // Counters, sync delay and registered status outputs.
    always_ff @(posedge clk) begin
        if (rstn) begin
            sync_in_d   <= 1'b0;
            pos_q       <= '0;
            frame_cnt   <= '0;
            window_en   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            busy        <= 1'b0;
            win_overrun <= 1'b0;
        end else begin
            sync_in_d   <= sync_in;
            pos_q       <= pos_nxt;
            frame_cnt   <= frame_cnt_nxt;
            window_en   <= window_nxt;
            frame_start <= frame_start_nxt;
            done        <= done_nxt;
            cfg_err     <= cfg_err_nxt;
            busy        <= busy_nxt;
            win_overrun <= arm_accept ? 1'b0 : (win_overrun | overrun_set_c);
        end
    end

    // Stream gate driven by the registered window.
    tdd_axis_gate #(
        .DATA_W (DATA_W)
    ) u_axis_gate (
        .window_en     (window_en),
        .window_en_nxt (window_nxt),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overrun_set_c (overrun_set_c)
    );

endmodule

// File: tb/tb_tdd_frame_gate.sv
// Randomized self-checking bench for tdd_frame_gate (resync and no-resync instances).
module tb_tdd_frame_gate;

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn, sync_in, arm, stop;
    logic [CNT_W-1:0]  cfg_frame_len, cfg_delay, cfg_on_len, cfg_num_frames;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid, m_tready;

    logic [1:0]              s_tready_o, m_tvalid_o, win_o, fs_o, busy_o, done_o, cerr_o, ov_o;
    logic [1:0][DATA_W-1:0]  m_tdata_o;
    logic [1:0][CNT_W-1:0]   fc_o;

    // Instance 0 restarts on resync, instance 1 ignores sync while running.
    tdd_frame_gate #(.CNT_W(CNT_W), .RESYNC_EN(1'b1), .DATA_W(DATA_W)) u_dut_rs (
        .clk(clk), .rstn(rstn), .sync_in(sync_in), .arm(arm), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_delay(cfg_delay), .cfg_on_len(cfg_on_len),
        .cfg_num_frames(cfg_num_frames),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_o[0]),
        .m_axis_tdata(m_tdata_o[0]), .m_axis_tvalid(m_tvalid_o[0]), .m_axis_tready(m_tready),
        .window_en(win_o[0]), .frame_start(fs_o[0]), .frame_cnt(fc_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .cfg_err(cerr_o[0]), .win_overrun(ov_o[0])
    );

    tdd_frame_gate #(.CNT_W(CNT_W), .RESYNC_EN(1'b0), .DATA_W(DATA_W)) u_dut_nr (
        .clk(clk), .rstn(rstn), .sync_in(sync_in), .arm(arm), .stop(stop),
        .cfg_frame_len(cfg_frame_len), .cfg_delay(cfg_delay), .cfg_on_len(cfg_on_len),
        .cfg_num_frames(cfg_num_frames),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready_o[1]),
        .m_axis_tdata(m_tdata_o[1]), .m_axis_tvalid(m_tvalid_o[1]), .m_axis_tready(m_tready),
        .window_en(win_o[1]), .frame_start(fs_o[1]), .frame_cnt(fc_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .cfg_err(cerr_o[1]), .win_overrun(ov_o[1])
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // Behavioural model: mode 0 idle, 1 armed, 2 running; t is the cycle within the frame.
    int              m_mode [2];
    longint unsigned m_t [2], m_cnt [2], m_len [2], m_dly [2], m_on [2], m_num [2];
    bit              m_ov [2], m_cerr [2];
    bit              m_sync_prev;

    function automatic bit mwin(int i);
        return (m_mode[i] == 2) && (m_t[i] >= m_dly[i]) && (m_t[i] < m_dly[i] + m_on[i]);
    endfunction

    function automatic bit mfs(int i);
        return (m_mode[i] == 2) && (m_t[i] == 0);
    endfunction

    function automatic bit mdone(int i);
        return (m_mode[i] == 2) && (m_t[i] == m_len[i] - 1) && (m_num[i] != 0) &&
               (m_cnt[i] + 1 >= m_num[i]);
    endfunction

    task automatic model_step();
        bit edge_c, w0;
        edge_c = sync_in && !m_sync_prev;
        for (int i = 0; i < 2; i++) begin
            w0        = mwin(i);
            m_cerr[i] = 1'b0;
            if (rstn) begin
                m_mode[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_ov[i] = 1'b0;
            end else begin
                if (stop) begin
                    m_mode[i] = 0;
                end else begin
                    case (m_mode[i])
                        0: if (arm) begin
                            if (cfg_frame_len < 2) begin
                                m_cerr[i] = 1'b1;
                            end else begin
                                m_len[i] = cfg_frame_len; m_dly[i] = cfg_delay;
                                m_on[i]  = cfg_on_len;    m_num[i] = cfg_num_frames;
                                m_cnt[i] = 0; m_ov[i] = 1'b0; m_mode[i] = 1;
                            end
                        end
                        1: if (edge_c) begin
                            m_mode[i] = 2; m_t[i] = 0;
                        end
                        default: begin
                            if (m_t[i] == m_len[i] - 1) begin
                                m_cnt[i]++;
                                if (m_num[i] != 0 && m_cnt[i] >= m_num[i]) m_mode[i] = 0;
                                else m_t[i] = 0;
                            end else if (i == 0 && edge_c) begin
                                m_cnt[i]++; m_t[i] = 0;
                            end else begin
                                m_t[i]++;
                            end
                        end
                    endcase
                end
                if (w0 && s_tvalid && !mwin(i)) m_ov[i] = 1'b1;
            end
        end
        m_sync_prev = rstn ? 1'b0 : sync_in;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic cmp_regs();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("window_en[%0d]", i),   64'(win_o[i]),  64'(mwin(i)));
            chk($sformatf("frame_start[%0d]", i), 64'(fs_o[i]),   64'(mfs(i)));
            chk($sformatf("done[%0d]", i),        64'(done_o[i]), 64'(mdone(i)));
            chk($sformatf("busy[%0d]", i),        64'(busy_o[i]), 64'(m_mode[i] != 0));
            chk($sformatf("cfg_err[%0d]", i),     64'(cerr_o[i]), 64'(m_cerr[i]));
            chk($sformatf("win_overrun[%0d]", i), 64'(ov_o[i]),   64'(m_ov[i]));
            chk($sformatf("frame_cnt[%0d]", i),   64'(fc_o[i]),   64'(32'(m_cnt[i])));
        end
    endtask

    task automatic cmp_comb();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("m_tvalid[%0d]", i), 64'(m_tvalid_o[i]), 64'(s_tvalid & mwin(i)));
            chk($sformatf("s_tready[%0d]", i), 64'(s_tready_o[i]), 64'(m_tready & mwin(i)));
            chk($sformatf("m_tdata[%0d]", i),  64'(m_tdata_o[i]),  64'(s_tdata));
        end
    endtask

    // One clock: check stream gating, advance DUT and model, check registered outputs.
    task automatic tick();
        #1;
        if (chk_en) cmp_comb();
        @(posedge clk);
        cyc++;
        model_step();
        if (rstn) chk_en = 1'b1;
        #1;
        if (chk_en) cmp_regs();
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic set_cfg(input int len, input int dly, input int on, input int num);
        cfg_frame_len  = CNT_W'(len);
        cfg_delay      = CNT_W'(dly);
        cfg_on_len     = CNT_W'(on);
        cfg_num_frames = CNT_W'(num);
    endtask

    // Arm, then a one-cycle sync pulse; returns in the cycle with pos=0.
    task automatic start_run(input int len, input int dly, input int on, input int num);
        set_cfg(len, dly, on, num);
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        sync_in = 1'b1; tick(); sync_in = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1; tick(); stop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int hold;
        rstn = 1'b1; sync_in = 1'b0; arm = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0);
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        tick(); tick();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_cnt",  64'(fc_o[0]), 64'd0);
        chk("rst_win",  64'(win_o), 64'd0);
        rstn = 1'b0;

        // Two-frame run with sync high for cycles 20..29; config changed mid-run.
        set_cfg(10, 2, 3, 2);
        wait_cyc(5); arm = 1'b1; tick(); arm = 1'b0;
        wait_cyc(20); sync_in = 1'b1;
        while (cyc < 41) begin
            tick();
            if (cyc == 25) cfg_frame_len = CNT_W'(3);
            if (cyc == 30) sync_in = 1'b0;
            case (cyc)
                21, 31:         chk("lit_frame_start", 64'(fs_o[0]), 64'd1);
                23, 25, 33, 35: chk("lit_win_on", 64'(win_o[0]), 64'd1);
                26, 36:         chk("lit_win_off", 64'(win_o[0]), 64'd0);
                40: begin
                    chk("lit_done", 64'(done_o[0]), 64'd1);
                    chk("lit_busy_last", 64'(busy_o[0]), 64'd1);
                end
                41: begin
                    chk("lit_busy_end", 64'(busy_o[0]), 64'd0);
                    chk("lit_cnt_end", 64'(fc_o[0]), 64'd2);
                    chk("lit_done_end", 64'(done_o[0]), 64'd0);
                end
                default: ;
            endcase
        end

        // Rejected arms.
        set_cfg(1, 0, 0, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("lit_cfg_err", 64'(cerr_o[0]), 64'd1);
        chk("lit_cfg_err_busy", 64'(busy_o[0]), 64'd0);
        tick();
        chk("lit_cfg_err_pulse", 64'(cerr_o[0]), 64'd0);
        set_cfg(0, 0, 0, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("lit_cfg_err_zero", 64'(cerr_o[1]), 64'd1);

        // Window truncated at frame end.
        start_run(8, 6, 5, 0);
        repeat (6) tick();
        chk("lit_trunc_pos6", 64'(win_o[0]), 64'd1);
        tick();
        chk("lit_trunc_pos7", 64'(win_o[0]), 64'd1);
        tick();
        chk("lit_trunc_wrap_win", 64'(win_o[0]), 64'd0);
        chk("lit_trunc_wrap_fs", 64'(fs_o[0]), 64'd1);
        do_stop();

        // Continuous stream with the source always valid.
        s_tvalid = 1'b1; m_tready = 1'b1;
        start_run(6, 1, 2, 0);
        chk("lit_ov_start", 64'(ov_o[0]), 64'd0);
        tick();
        chk("lit_beat_tvalid", 64'(m_tvalid_o[0]), 64'd1);
        chk("lit_beat_tready", 64'(s_tready_o[0]), 64'd1);
        tick();
        chk("lit_ov_before", 64'(ov_o[0]), 64'd0);
        tick();
        chk("lit_ov_after", 64'(ov_o[0]), 64'd1);
        chk("lit_closed_tvalid", 64'(m_tvalid_o[0]), 64'd0);
        repeat (10) tick();
        do_stop();
        set_cfg(6, 1, 2, 0);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("lit_ov_clear", 64'(ov_o[0]), 64'd0);
        do_stop();
        s_tvalid = 1'b0;

        // Second sync edge at pos=4.
        start_run(10, 0, 2, 0);
        repeat (4) tick();
        sync_in = 1'b1; tick(); sync_in = 1'b0;
        chk("lit_resync_fs", 64'(fs_o[0]), 64'd1);
        chk("lit_resync_cnt", 64'(fc_o[0]), 64'd1);
        chk("lit_noresync_fs", 64'(fs_o[1]), 64'd0);
        chk("lit_noresync_cnt", 64'(fc_o[1]), 64'd0);
        repeat (5) tick();
        chk("lit_noresync_wrap", 64'(fs_o[1]), 64'd1);
        chk("lit_resync_mid", 64'(fs_o[0]), 64'd0);
        do_stop();

        // Stop inside the window.
        start_run(10, 2, 4, 0);
        repeat (3) tick();
        chk("lit_stop_win_before", 64'(win_o[0]), 64'd1);
        do_stop();
        chk("lit_stop_win", 64'(win_o[0]), 64'd0);
        chk("lit_stop_busy", 64'(busy_o[0]), 64'd0);

        // Reset in the middle of a run.
        start_run(5, 0, 3, 0);
        repeat (7) tick();
        chk("lit_pre_rst_cnt", 64'(fc_o[0]), 64'd1);
        rstn = 1'b1; tick(); rstn = 1'b0;
        chk("lit_rst_busy", 64'(busy_o[0]), 64'd0);
        chk("lit_rst_cnt", 64'(fc_o[0]), 64'd0);
        chk("lit_rst_win", 64'(win_o[0]), 64'd0);

        // Random traffic, config churn, sync pulses, arm/stop/reset.
        hold = 3;
        for (int n = 0; n < 8000; n++) begin
            set_cfg($urandom_range(0, 12), $urandom_range(0, 12),
                    $urandom_range(0, 12), $urandom_range(0, 4));
            arm  = ($urandom_range(0, 24) == 0);
            stop = ($urandom_range(0, 199) == 0);
            rstn = ($urandom_range(0, 2999) == 0);
            if (hold == 0) begin
                sync_in = ~sync_in;
                hold = sync_in ? int'($urandom_range(1, 6)) : int'($urandom_range(2, 40));
            end else begin
                hold--;
            end
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = DATA_W'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
